// File: rtl/tff_counter_pkg.sv
// Shared direction constants and next-count arithmetic for the T-flip-flop up/down counter.
package tff_counter_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Wrapping successor/predecessor within 0..modulo-1; int-wide so any WIDTH up to 16 fits.
   function automatic int unsigned next_count(input int unsigned cnt,
                                              input logic        up_dn,
                                              input int unsigned modulo);
      if (up_dn == DIR_DN) begin
         return (cnt == 0) ? modulo - 1 : cnt - 1;
      end
      return (cnt == modulo - 1) ? 0 : cnt + 1;
   endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: Q toggles on a clock edge when T is high; async active-high clear.
module tff_cell (
   input  logic T,
   input  logic clk,
   input  logic reset,
   output logic Q
);

   logic q_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= 1'b0;
      end else if (T) begin
         q_q <= ~q_q;
      end
   end

   assign Q = q_q;

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo up/down counter built from T flip-flops, with load and a registered terminal-count pulse.
// Define TCNT_SATURATE_EN to hold at the range boundaries instead of wrapping.
module tff_updown_counter
   import tff_counter_pkg::*;
#(
   parameter int unsigned WIDTH  = 3,
   parameter int unsigned MODULO = 2 ** WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MODULO - 1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] toggle;
   logic             at_bound;
   logic             tc_q;
   logic             tc_d;

   always_comb begin
      count_d  = count_q;
      tc_d     = 1'b0;
      at_bound = (up_dn == DIR_UP) ? (count_q == MaxCnt) : (count_q == '0);
      step     = WIDTH'(next_count(32'(count_q), up_dn, MODULO));
      if (load) begin
         // Out-of-range load values clamp so the count never leaves 0..MODULO-1.
         count_d = (32'(load_val) >= MODULO) ? MaxCnt : load_val;
      end else if (en) begin
`ifdef TCNT_SATURATE_EN
         if (!at_bound) begin
            count_d = step;
            tc_d    = (up_dn == DIR_UP) ? (step == MaxCnt) : (step == '0);
         end
`else
         count_d = step;
         tc_d    = at_bound;
`endif
      end
   end

   assign toggle = count_d ^ count_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
         .T     (toggle[i]),
         .clk   (clk),
         .reset (reset),
         .Q     (count_q[i])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tc_q <= 1'b0;
      end else begin
         tc_q <= tc_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed self-checking bench: WIDTH=4/MODULO=10 instance plus a default 3-bit instance.
module tb_tff_updown_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       up_dn = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] count;
   logic       tc;

   logic       en3 = 1'b0;
   logic [2:0] count3;
   logic       tc3;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   tff_updown_counter #(
      .WIDTH  (4),
      .MODULO (10)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc)
   );

   tff_updown_counter u_dut3 (
      .clk      (clk),
      .reset    (reset),
      .en       (en3),
      .up_dn    (1'b1),
      .load     (1'b0),
      .load_val (3'd0),
      .count    (count3),
      .tc       (tc3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_c;

      // Asynchronous reset, before any clock edge.
      #1 reset = 1'b1;
      #1;
      check("rst_count", 32'(count), 0);
      check("rst_tc", 32'(tc), 0);
      check("rst_count3", 32'(count3), 0);
      reset = 1'b0;

      // Count up 12 edges from 0.
      en = 1'b1;
      up_dn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
`ifdef TCNT_SATURATE_EN
         exp_c = (i + 1 > 9) ? 9 : i + 1;
         check("up_count", 32'(count), 32'(exp_c));
         check("up_tc", 32'(tc), (i == 8) ? 1 : 0);
`else
         exp_c = (i + 1) % 10;
         check("up_count", 32'(count), 32'(exp_c));
         check("up_tc", 32'(tc), (exp_c == 0) ? 1 : 0);
`endif
      end

      // Load 0, then count down through the bottom.
      load = 1'b1;
      load_val = 4'd0;
      tick();
      check("load0_count", 32'(count), 0);
      check("load0_tc", 32'(tc), 0);
      load = 1'b0;
      up_dn = 1'b0;
      tick();
`ifdef TCNT_SATURATE_EN
      check("dn_hold0", 32'(count), 0);
      check("dn_hold0_tc", 32'(tc), 0);
`else
      check("dn_wrap", 32'(count), 9);
      check("dn_wrap_tc", 32'(tc), 1);
      tick();
      check("dn_8", 32'(count), 8);
      check("dn_8_tc", 32'(tc), 0);
`endif

      // Load has priority over en; out-of-range value clamps to MODULO-1.
      load = 1'b1;
      en = 1'b1;
      load_val = 4'd13;
      tick();
      check("load13_count", 32'(count), 9);
      check("load13_tc", 32'(tc), 0);
      load_val = 4'd5;
      tick();
      check("load5_count", 32'(count), 5);

      // Hold.
      load = 1'b0;
      en = 1'b0;
      tick();
      check("hold_count", 32'(count), 5);
      check("hold_tc", 32'(tc), 0);

      // Up to 6, then reset between edges.
      en = 1'b1;
      up_dn = 1'b1;
      tick();
      check("up6_count", 32'(count), 6);
      #2 reset = 1'b1;
      #1;
      check("midrst_count", 32'(count), 0);
      check("midrst_tc", 32'(tc), 0);
      tick();
      tick();
      check("rsthold_count", 32'(count), 0);
      reset = 1'b0;
      tick();
      check("postrst_count", 32'(count), 1);

`ifdef TCNT_SATURATE_EN
      // Saturate at the top: single tc pulse, then step back down.
      load = 1'b1;
      load_val = 4'd8;
      tick();
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("sat_count", 32'(count), 9);
         check("sat_tc", 32'(tc), (i == 0) ? 1 : 0);
      end
      up_dn = 1'b0;
      tick();
      check("sat_dn_count", 32'(count), 8);
`endif

      // Default 3-bit instance: 16 up edges from reset.
      en = 1'b0;
      reset = 1'b1;
      #2 reset = 1'b0;
      en3 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
`ifdef TCNT_SATURATE_EN
         exp_c = (i + 1 > 7) ? 7 : i + 1;
         check("w3_count", 32'(count3), 32'(exp_c));
         check("w3_tc", 32'(tc3), (i == 6) ? 1 : 0);
`else
         exp_c = (i + 1) % 8;
         check("w3_count", 32'(count3), 32'(exp_c));
         check("w3_tc", 32'(tc3), (exp_c == 0) ? 1 : 0);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
